// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM states and PC constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_FETCH      = 2'd1,
        ST_WAIT_SPACE = 2'd2,
        ST_KILL       = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

endpackage

// File: rtl/fetch_buf.sv
// 2-entry FIFO of {inst, pc} between instruction memory and decode.
// Latency: push visible at head the cycle after the push edge.
// Backpressure: caller only pushes when a slot is free (a same-cycle pop counts); flush clears all entries.
module fetch_buf
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [31:0] push_inst,
    input  logic [31:0] push_pc,
    input  logic        pop,
    input  logic        flush,
    output logic [1:0]  cnt,
    output logic        head_vld,
    output logic [31:0] head_inst,
    output logic [31:0] head_pc
);

    logic [1:0][31:0] inst_q, inst_d;
    logic [1:0][31:0] pc_q, pc_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;

    // Next-state: flush wins over push; pop and push may coincide when full.
    always_comb begin
        inst_d   = inst_q;
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            if (push) begin
                inst_d[wr_ptr_q] = push_inst;
                pc_d[wr_ptr_q]   = push_pc;
                wr_ptr_d         = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q   <= '0;
            pc_q     <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            inst_q   <= inst_d;
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cnt       = cnt_q;
    assign head_vld  = (cnt_q != 2'd0);
    assign head_inst = inst_q[rd_ptr_q];
    assign head_pc   = pc_q[rd_ptr_q];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC, one-outstanding imem req/ack, 2-entry queue to decode; optional FETCH_ALIGN_CHECK_EN.
// Latency: ack to Inst_valid 1 cycle; redirect to new request 1 cycle (after the killed ack if one is in flight).
// Backpressure: stops requesting (WAIT_SPACE) while the queue would be full; Inst_ready pops the head.
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        Clk,
    input  logic        Clrn,
    input  logic        Redirect,
    input  logic [31:0] Target,
    output logic        Imem_req,
    output logic [31:0] Imem_addr,
    input  logic        Imem_ack,
    input  logic [31:0] Imem_rdata,
    output logic        Inst_valid,
    output logic [31:0] Inst,
    output logic [31:0] Inst_pc,
    input  logic        Inst_ready,
    output logic        Misalign
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         req_q, req_d;
    logic [31:0]  addr_q, addr_d;

    logic [1:0]   buf_cnt;
    logic [1:0]   cnt_after;
    logic         pop;
    logic         push;
    logic         fetch_ack;
    logic [31:0]  tgt_aligned;
    logic [31:0]  next_pc;

    assign tgt_aligned = {Target[31:2], 2'b00};
    assign next_pc     = addr_q + PC_STEP;
    assign pop         = Inst_valid & Inst_ready;
    assign fetch_ack   = (state_q == ST_FETCH) & Imem_ack;
    assign push        = fetch_ack & ~Redirect;
    assign cnt_after   = buf_cnt + {1'b0, push} - {1'b0, pop};

    // Next state, PC and registered request; redirect has top priority.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        if (Redirect) begin
            pc_d = tgt_aligned;
            if (req_q && !Imem_ack) begin
                // In-flight request must complete with its address held.
                state_d = ST_KILL;
            end else begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
                addr_d  = tgt_aligned;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_FETCH;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
                ST_FETCH: begin
                    if (Imem_ack) begin
                        pc_d = next_pc;
                        if (cnt_after < 2'd2) begin
                            addr_d = next_pc;
                        end else begin
                            state_d = ST_WAIT_SPACE;
                            req_d   = 1'b0;
                        end
                    end
                end
                ST_WAIT_SPACE: begin
                    if (cnt_after < 2'd2) begin
                        state_d = ST_FETCH;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                    end
                end
                ST_KILL: begin
                    if (Imem_ack) begin
                        state_d = ST_FETCH;
                        addr_d  = pc_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    // FSM, PC and request registers.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    assign Imem_req  = req_q;
    assign Imem_addr = addr_q;

    fetch_buf u_fetch_buf (
        .clk       (Clk),
        .rst_n     (Clrn),
        .push      (push),
        .push_inst (Imem_rdata),
        .push_pc   (addr_q),
        .pop       (pop),
        .flush     (Redirect),
        .cnt       (buf_cnt),
        .head_vld  (Inst_valid),
        .head_inst (Inst),
        .head_pc   (Inst_pc)
    );

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    // One-cycle flag for a redirect to a non-word-aligned target.
    always_comb begin
        misalign_d = Redirect & (Target[1:0] != 2'b00);
    end

    // Misalign pulse register.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign Misalign = misalign_q;
`else
    // Low target bits are dropped silently in this build.
    logic unused_tgt_lsb;
    assign unused_tgt_lsb = ^Target[1:0];
    assign Misalign       = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: streaming, stall, kill, redirect+ack, PC wrap, misalign, async reset.
// Latency: n/a.
// Backpressure: Inst_ready driven directly by the vectors.
module tb_if_fetch_unit;

    logic        Clk;
    logic        Clrn;
    logic        Redirect;
    logic [31:0] Target;
    logic        Imem_req;
    logic [31:0] Imem_addr;
    logic        Imem_ack;
    logic [31:0] Imem_rdata;
    logic        Inst_valid;
    logic [31:0] Inst;
    logic [31:0] Inst_pc;
    logic        Inst_ready;
    logic        Misalign;

    int n_vec;
    int n_bad;

    logic exp_mis;

    if_fetch_unit dut (
        .Clk        (Clk),
        .Clrn       (Clrn),
        .Redirect   (Redirect),
        .Target     (Target),
        .Imem_req   (Imem_req),
        .Imem_addr  (Imem_addr),
        .Imem_ack   (Imem_ack),
        .Imem_rdata (Imem_rdata),
        .Inst_valid (Inst_valid),
        .Inst       (Inst),
        .Inst_pc    (Inst_pc),
        .Inst_ready (Inst_ready),
        .Misalign   (Misalign)
    );

    // Memory image: each word is its address xor a fixed tag.
    assign Imem_rdata = Imem_addr ^ 32'hDEAD_0000;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic ack, input logic rdy, input logic redir, input logic [31:0] tgt);
        Imem_ack   = ack;
        Inst_ready = rdy;
        Redirect   = redir;
        Target     = tgt;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
`ifdef FETCH_ALIGN_CHECK_EN
        exp_mis = 1'b1;
`else
        exp_mis = 1'b0;
`endif
        Clrn = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        #12;
        // Reset state, with a stray ack that must be ignored.
        Imem_ack = 1'b1;
        #10;
        chk("rst_req",   {31'd0, Imem_req},   32'd0);
        chk("rst_addr",  Imem_addr,           32'h0);
        chk("rst_vld",   {31'd0, Inst_valid}, 32'd0);
        chk("rst_inst",  Inst,                32'h0);
        chk("rst_ipc",   Inst_pc,             32'h0);
        chk("rst_mis",   {31'd0, Misalign},   32'd0);
        Imem_ack = 1'b0;
        Clrn     = 1'b1;

        // First edge after reset: request at RESET_PC.
        tick();
        chk("first_req",  {31'd0, Imem_req},   32'd1);
        chk("first_addr", Imem_addr,           32'h0);
        chk("first_vld",  {31'd0, Inst_valid}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);

        // Zero-wait streaming.
        tick();
        chk("s1_addr", Imem_addr, 32'h4);
        chk("s1_vld",  {31'd0, Inst_valid}, 32'd1);
        chk("s1_ipc",  Inst_pc,   32'h0);
        chk("s1_inst", Inst,      32'hDEAD_0000);
        tick();
        chk("s2_addr", Imem_addr, 32'h8);
        chk("s2_ipc",  Inst_pc,   32'h4);
        chk("s2_inst", Inst,      32'hDEAD_0004);

        // Stall decode: 0x8 fills the queue, fetch must stop.
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        chk("full_req", {31'd0, Imem_req}, 32'd0);
        chk("full_ipc", Inst_pc, 32'h4);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_req", {31'd0, Imem_req}, 32'd0);
            chk("wait_ipc", Inst_pc, 32'h4);
        end

        // Release: one pop reopens fetch at 0xC.
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        chk("rel_req",  {31'd0, Imem_req}, 32'd1);
        chk("rel_addr", Imem_addr, 32'hC);
        chk("rel_ipc",  Inst_pc,   32'h8);
        chk("rel_inst", Inst,      32'hDEAD_0008);
        tick();
        chk("drain_vld", {31'd0, Inst_valid}, 32'd0);
        chk("drain_addr", Imem_addr, 32'hC);

        // Redirect while 0xC is outstanding; ack delayed.
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0100);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        chk("kill_addr0", Imem_addr, 32'hC);
        chk("kill_req0",  {31'd0, Imem_req}, 32'd1);
        tick();
        chk("kill_addr1", Imem_addr, 32'hC);
        tick();
        chk("kill_addr2", Imem_addr, 32'hC);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        chk("kill_next", Imem_addr, 32'h100);
        chk("kill_vld",  {31'd0, Inst_valid}, 32'd0);
        tick();
        chk("tgt_addr", Imem_addr, 32'h104);
        chk("tgt_ipc",  Inst_pc,   32'h100);
        chk("tgt_inst", Inst,      32'hDEAD_0100);

        // Redirect coincident with ack of 0x104, queue holding 0x100.
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0200);
        tick();
        chk("rack_addr", Imem_addr, 32'h200);
        chk("rack_vld",  {31'd0, Inst_valid}, 32'd0);
        chk("rack_req",  {31'd0, Imem_req}, 32'd1);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        chk("rack_ipc",  Inst_pc, 32'h200);
        chk("rack_addr2", Imem_addr, 32'h204);

        // PC wrap at the top of the address space.
        drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr0", Imem_addr, 32'hFFFF_FFFC);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        chk("wrap_addr1", Imem_addr, 32'h0);
        chk("wrap_ipc",   Inst_pc,   32'hFFFF_FFFC);
        chk("wrap_mis",   {31'd0, Misalign}, 32'd0);

        // Misaligned target: aligned fetch, flag only with the check enabled.
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0102);
        tick();
        chk("mis_addr", Imem_addr, 32'h100);
        chk("mis_flag", {31'd0, Misalign}, {31'd0, exp_mis});
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        chk("mis_clr",  {31'd0, Misalign}, 32'd0);
        chk("mis_hold", Imem_addr, 32'h100);

        // Asynchronous reset mid-fetch.
        Clrn = 1'b0;
        #1;
        chk("arst_req",  {31'd0, Imem_req}, 32'd0);
        chk("arst_addr", Imem_addr, 32'h0);
        chk("arst_vld",  {31'd0, Inst_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
